// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte-lane stores plus an MMIO page (TOHOST, CYCLE, TX FIFO).
// Define DMEM_UART_EN to build the TX FIFO; without it TXSTAT reads "empty" and the TX port is tied off.
module dmem_responder #(
   parameter int    WIDTH     = 32,
   parameter int    DADDR     = 16,
   parameter int    RAM_AW    = 12,
   parameter int    TXQ_AW    = 2,
   parameter string INIT_FILE = ""
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DADDR-1:0] dmem_addr,
   input  logic [WIDTH-1:0] dmem_wdata,
   input  logic [3:0]       dmem_wr_en,
   output logic [WIDTH-1:0] dmem_rdata,
   output logic             halt,
   output logic [WIDTH-1:0] exit_code,
   output logic             tx_valid,
   output logic [7:0]       tx_data,
   input  logic             tx_ready
);

   localparam int RAM_WORDS = 1 << RAM_AW;

   logic [WIDTH-1:0]  ram_r [0:RAM_WORDS-1];
   logic              mmio_s;
   logic [RAM_AW-1:0] ram_idx_s;
   logic [5:0]        reg_off_s;
   logic              tohost_wr_s;
   logic              halt_r;
   logic [WIDTH-1:0]  exit_code_r;
   logic [WIDTH-1:0]  cycle_r;
   logic [WIDTH-1:0]  txstat_s;
   logic              unused_s;

   assign mmio_s    = &dmem_addr[DADDR-1:8];
   assign ram_idx_s = dmem_addr[RAM_AW+1:2];
   assign reg_off_s = dmem_addr[7:2];
   assign halt      = halt_r;
   assign exit_code = exit_code_r;

   // RAM byte-lane store; MMIO accesses never reach the RAM even though the index aliases.
   always_ff @(posedge clk) begin
      if (!mmio_s) begin
         for (int i = 0; i < 4; i++) begin
            if (dmem_wr_en[i]) begin
               ram_r[ram_idx_s][8*i +: 8] <= dmem_wdata[8*i +: 8];
            end
         end
      end
   end

   assign tohost_wr_s = mmio_s && (reg_off_s == 6'h00) && (|dmem_wr_en) &&
                        (dmem_wdata != {WIDTH{1'b0}}) && !halt_r;

   // Halt/exit latch and free-running cycle counter (frozen once halted)
   always_ff @(posedge clk) begin
      if (reset) begin
         halt_r      <= 1'b0;
         exit_code_r <= {WIDTH{1'b0}};
         cycle_r     <= {WIDTH{1'b0}};
      end else begin
         if (tohost_wr_s) begin
            halt_r      <= 1'b1;
            exit_code_r <= dmem_wdata;
         end
         if (!halt_r) begin
            cycle_r <= cycle_r + {{(WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

`ifdef DMEM_UART_EN
   localparam logic [TXQ_AW:0] FULL_CNT = {1'b1, {TXQ_AW{1'b0}}};

   logic [7:0]        txq_r [0:(1<<TXQ_AW)-1];
   logic [TXQ_AW-1:0] wr_ptr_r;
   logic [TXQ_AW-1:0] rd_ptr_r;
   logic [TXQ_AW:0]   count_r;
   logic              ovf_r;
   logic              full_s;
   logic              empty_s;
   logic              push_req_s;
   logic              push_s;
   logic              pop_s;
   logic              ovf_clr_s;

   assign full_s     = (count_r == FULL_CNT);
   assign empty_s    = (count_r == {(TXQ_AW+1){1'b0}});
   assign push_req_s = mmio_s && (reg_off_s == 6'h02) && dmem_wr_en[0];
   // Fullness is judged on the pre-edge count, so a same-cycle pop does not rescue a push.
   assign push_s     = push_req_s && !full_s;
   assign pop_s      = !empty_s && tx_ready;
   assign ovf_clr_s  = mmio_s && (reg_off_s == 6'h03) && dmem_wr_en[2] && dmem_wdata[16];
   assign tx_valid   = !empty_s;
   assign tx_data    = empty_s ? 8'h00 : txq_r[rd_ptr_r];
   assign unused_s   = &{1'b0, dmem_addr[1:0]};

   // FIFO storage, not reset
   always_ff @(posedge clk) begin
      if (push_s) begin
         txq_r[wr_ptr_r] <= dmem_wdata[7:0];
      end
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {TXQ_AW{1'b0}};
         rd_ptr_r <= {TXQ_AW{1'b0}};
         count_r  <= {(TXQ_AW+1){1'b0}};
         ovf_r    <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + TXQ_AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + TXQ_AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (TXQ_AW+1)'(1);
            2'b01:   count_r <= count_r - (TXQ_AW+1)'(1);
            default: count_r <= count_r;
         endcase
         if (push_req_s && full_s) begin
            ovf_r <= 1'b1;
         end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
         end
      end
   end

   // TXSTAT read word
   always_comb begin
      txstat_s           = {WIDTH{1'b0}};
      txstat_s[TXQ_AW:0] = count_r;
      txstat_s[8]        = full_s;
      txstat_s[9]        = empty_s;
      txstat_s[16]       = ovf_r;
   end
`else
   assign tx_valid = 1'b0;
   assign tx_data  = 8'h00;
   assign txstat_s = {{(WIDTH-10){1'b0}}, 1'b1, 9'h000};
   assign unused_s = &{1'b0, dmem_addr[1:0], tx_ready};
`endif

   // Combinational read mux; RAM read returns the pre-write word during a store
   always_comb begin
      dmem_rdata = {WIDTH{1'b0}};
      if (mmio_s) begin
         case (reg_off_s)
            6'h00:   dmem_rdata = exit_code_r;
            6'h01:   dmem_rdata = cycle_r;
            6'h03:   dmem_rdata = txstat_s;
            default: dmem_rdata = {WIDTH{1'b0}};
         endcase
      end else begin
         dmem_rdata = ram_r[ram_idx_s];
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; FIFO scenarios run when DMEM_UART_EN is defined.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] dmem_addr = 16'h0000;
   logic [31:0] dmem_wdata = 32'h0;
   logic [3:0]  dmem_wr_en = 4'b0000;
   logic [31:0] dmem_rdata;
   logic        halt;
   logic [31:0] exit_code;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;

   int          n_checks = 0;
   int          n_fail = 0;
   logic        exp_halt = 1'b0;
   logic [31:0] cyc_model = 32'h0;

   dmem_responder dut (
      .clk        (clk),
      .reset      (reset),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_wr_en (dmem_wr_en),
      .dmem_rdata (dmem_rdata),
      .halt       (halt),
      .exit_code  (exit_code),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready)
   );

   always #5 clk = ~clk;

   // reference cycle counter: counts edges while the bench expects the core not halted
   always @(posedge clk) begin
      if (reset) cyc_model <= 32'h0;
      else if (!exp_halt) cyc_model <= cyc_model + 32'h1;
   end

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // called at a negedge: drive one write cycle, return at the following negedge
   task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] en);
      dmem_addr  = a;
      dmem_wdata = d;
      dmem_wr_en = en;
      @(negedge clk);
      dmem_wr_en = 4'b0000;
      dmem_wdata = 32'h0;
   endtask

   task automatic read_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
      dmem_addr  = a;
      dmem_wr_en = 4'b0000;
      #1;
      check_value(tag, dmem_rdata, exp);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      check_value("rst_halt", {31'h0, halt}, 32'h0);
      check_value("rst_exit", exit_code, 32'h0);
      check_value("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check_value("rst_tx_data", {24'h0, tx_data}, 32'h0);
      reset = 1'b0;

      // cycle counter counts edges since reset release; writes to it are ignored
      read_check("cycle_0", 16'hFF04, 32'd0);
      repeat (5) @(negedge clk);
      read_check("cycle_5", 16'hFF04, 32'd5);
      bus_write(16'hFF04, 32'h0000_1234, 4'b1111);
      read_check("cycle_wr_ignored", 16'hFF04, 32'd6);

      // byte-lane stores and aliasing
      bus_write(16'h0010, 32'hAABB_CCDD, 4'b1111);
      bus_write(16'h0010, 32'h0000_0011, 4'b0001);
      read_check("lane0", 16'h0010, 32'hAABB_CC11);
      read_check("alias", 16'h4010, 32'hAABB_CC11);
      bus_write(16'h0012, 32'h0099_0000, 4'b0100);
      read_check("lane2", 16'h0010, 32'hAA99_CC11);

      // read-during-write returns the old word
      bus_write(16'h0020, 32'hCAFE_F00D, 4'b1111);
      dmem_addr  = 16'h0020;
      dmem_wdata = 32'h1234_5678;
      dmem_wr_en = 4'b1111;
      #1;
      check_value("rdw_old", dmem_rdata, 32'hCAFE_F00D);
      @(negedge clk);
      dmem_wr_en = 4'b0000;
      read_check("rdw_new", 16'h0020, 32'h1234_5678);

      // MMIO page does not write the aliased RAM word; unmapped offsets read 0
      bus_write(16'h3F10, 32'h0101_0101, 4'b1111);
      bus_write(16'hFF10, 32'hDEAD_BEEF, 4'b1111);
      read_check("mmio_no_ram", 16'h3F10, 32'h0101_0101);
      read_check("mmio_unmapped", 16'hFF10, 32'h0);
      read_check("txdata_reads0", 16'hFF08, 32'h0);

`ifdef DMEM_UART_EN
      // fill past depth with the sink stalled
      read_check("txstat_empty", 16'hFF0C, 32'h0000_0200);
      bus_write(16'hFF08, 32'h0000_0041, 4'b0001);
      check_value("push_visible", {23'h0, tx_valid, tx_data}, 32'h0000_0141);
      for (int i = 1; i < 5; i++) bus_write(16'hFF08, 32'h41 + i, 4'b0001);
      read_check("txstat_full_ovf", 16'hFF0C, 32'h0001_0104);
      check_value("head_stable", {24'h0, tx_data}, 32'h41);
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_value("drain", {23'h0, tx_valid, tx_data}, 32'h0000_0141 + i);
         @(negedge clk);
      end
      tx_ready = 1'b0;
      check_value("drained_valid", {23'h0, tx_valid, tx_data}, 32'h0);
      read_check("txstat_ovf_sticky", 16'hFF0C, 32'h0001_0200);
      bus_write(16'hFF0C, 32'h0001_0000, 4'b0100);
      read_check("ovf_clear", 16'hFF0C, 32'h0000_0200);

      // simultaneous push/pop at count=2
      bus_write(16'hFF08, 32'h61, 4'b0001);
      bus_write(16'hFF08, 32'h62, 4'b0001);
      tx_ready = 1'b1;
      bus_write(16'hFF08, 32'h63, 4'b0001);
      tx_ready = 1'b0;
      read_check("pushpop_count", 16'hFF0C, 32'h0000_0002);
      check_value("pushpop_head", {24'h0, tx_data}, 32'h62);
      tx_ready = 1'b1;
      @(negedge clk);
      check_value("pushpop_next", {24'h0, tx_data}, 32'h63);
      @(negedge clk);
      tx_ready = 1'b0;
      check_value("pushpop_empty", {31'h0, tx_valid}, 32'h0);

      // push into a full FIFO is dropped even with a same-cycle pop
      for (int i = 0; i < 4; i++) bus_write(16'hFF08, 32'h71 + i, 4'b0001);
      tx_ready = 1'b1;
      bus_write(16'hFF08, 32'h75, 4'b0001);
      tx_ready = 1'b0;
      read_check("full_pop_push", 16'hFF0C, 32'h0001_0003);
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_value("full_pop_order", {23'h0, tx_valid, tx_data}, 32'h0000_0172 + i);
         @(negedge clk);
      end
      tx_ready = 1'b0;
      check_value("full_pop_dropped", {31'h0, tx_valid}, 32'h0);
      bus_write(16'hFF0C, 32'h0001_0000, 4'b0100);
`else
      bus_write(16'hFF08, 32'h0000_0041, 4'b0001);
      read_check("txstat_const", 16'hFF0C, 32'h0000_0200);
      check_value("tx_tied_off", {23'h0, tx_valid, tx_data}, 32'h0);
`endif

      // TOHOST: zero ignored, first non-zero latches, later writes ignored
      bus_write(16'hFF00, 32'h0, 4'b1111);
      check_value("halt_zero_wr", {31'h0, halt}, 32'h0);
      read_check("tohost_zero", 16'hFF00, 32'h0);
      dmem_addr  = 16'hFF00;
      dmem_wdata = 32'h0000_002A;
      dmem_wr_en = 4'b0001;
      #1;
      check_value("halt_pre_edge", {31'h0, halt}, 32'h0);
      @(negedge clk);
      dmem_wr_en = 4'b0000;
      exp_halt   = 1'b1;
      check_value("halt_set", {31'h0, halt}, 32'h1);
      check_value("exit_code", exit_code, 32'h2A);
      bus_write(16'hFF00, 32'h0000_0055, 4'b1111);
      check_value("exit_sticky", exit_code, 32'h2A);
      read_check("tohost_read", 16'hFF00, 32'h2A);
      read_check("cycle_frozen_a", 16'hFF04, cyc_model);
      @(negedge clk);
      read_check("cycle_frozen_b", 16'hFF04, cyc_model);

      // reset mid-drain
`ifdef DMEM_UART_EN
      for (int i = 0; i < 3; i++) bus_write(16'hFF08, 32'h81 + i, 4'b0001);
      check_value("pre_reset_head", {23'h0, tx_valid, tx_data}, 32'h0000_0181);
      tx_ready = 1'b1;
`endif
      reset = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      tx_ready = 1'b0;
      exp_halt = 1'b0;
      check_value("post_rst_tx", {23'h0, tx_valid, tx_data}, 32'h0);
      check_value("post_rst_halt", {31'h0, halt}, 32'h0);
      check_value("post_rst_exit", exit_code, 32'h0);
      read_check("post_rst_txstat", 16'hFF0C, 32'h0000_0200);
      read_check("post_rst_cycle", 16'hFF04, 32'h0);
      read_check("post_rst_ram", 16'h0010, 32'hAA99_CC11);
      @(negedge clk);
      read_check("post_rst_cycle1", 16'hFF04, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
